// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// Hits complete in zero stall cycles; misses and all stores go through a memory handshake.
module data_cache #(
  parameter int unsigned SETS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CacheEn,
  input  logic        MemWrite,
  input  logic [2:0]  DataWidth,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 30 - IW;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;
  state_t state;

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_mem  [SETS];
  logic [31:0]     data_mem [SETS];

  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic [31:0]   line;
  logic          hit;
  logic [3:0]    strb;
  logic [31:0]   wrep;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [31:0]   load_val;

  assign index = addr[2 +: IW];
  assign tag   = addr[31 -: TW];
  assign line  = data_mem[index];
  assign hit   = valid[index] && (tag_mem[index] == tag);

  // Reserved DataWidth codes fall into the default (word) arm.
  always_comb begin
    strb     = 4'b1111;
    wrep     = wdata;
    half_sel = addr[1] ? line[31:16] : line[15:0];
    byte_sel = line[{addr[1:0], 3'b000} +: 8];
    load_val = line;
    case (DataWidth[1:0])
      2'b01: begin
        strb     = addr[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        load_val = DataWidth[2] ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      2'b10: begin
        strb     = 4'b0001 << addr[1:0];
        wrep     = {4{wdata[7:0]}};
        load_val = DataWidth[2] ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      default: ;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    rdata = '0;
    case (state)
      IDLE: begin
        Stall = CacheEn && (MemWrite || !hit);
        if (CacheEn && !MemWrite && hit) rdata = load_val;
      end
      REFILL, WRITE: Stall = 1'b1;
      RESP: if (!MemWrite) rdata = load_val;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: if (CacheEn) begin
          if (hit) hit_count  <= hit_count + 16'd1;
          else     miss_count <= miss_count + 16'd1;
          if (MemWrite) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wrep;
            mem_wstrb <= strb;
          end else if (!hit) begin
            state     <= REFILL;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wstrb <= '0;
          end
        end
        REFILL: if (mem_ack) begin
          valid[index] <= 1'b1;
          mem_req      <= 1'b0;
          state        <= RESP;
        end
        WRITE: if (mem_ack) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= '0;
          state     <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays are not reset; updates are keyed on state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_mem[index] <= mem_rdata;
      tag_mem[index]  <= tag;
    end else if (state == WRITE && mem_ack && hit) begin
      for (int unsigned i = 0; i < 4; i++)
        if (mem_wstrb[i]) data_mem[index][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache against a word-array reference model
// of the cache lines and backing memory.
module tb_data_cache;
  localparam int unsigned SETS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CacheEn = 1'b0, MemWrite = 1'b0;
  logic [2:0]  DataWidth = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        Stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [15:0] hit_count, miss_count;

  data_cache #(.SETS(SETS)) dut (
    .clk(clk), .rst_n(rst_n), .CacheEn(CacheEn), .MemWrite(MemWrite),
    .DataWidth(DataWidth), .addr(addr), .wdata(wdata), .rdata(rdata),
    .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;

  // Reference model: line arrays, backing memory keyed by word address, counters.
  bit          mv [SETS];
  int unsigned mt [SETS];
  bit [31:0]   md [SETS];
  bit [31:0]   mem [int unsigned];
  bit [15:0]   m_hits = 0, m_miss = 0;

  function automatic bit [31:0] getmem(input int unsigned waddr);
    if (!mem.exists(waddr)) mem[waddr] = $urandom;
    return mem[waddr];
  endfunction

  function automatic int unsigned acc_size(input bit [2:0] dw);
    if (dw == 3'b001 || dw == 3'b101) return 2;
    if (dw == 3'b010 || dw == 3'b110) return 1;
    return 4;
  endfunction

  function automatic int unsigned acc_start(input bit [2:0] dw, input bit [31:0] a);
    int unsigned sz = acc_size(dw);
    if (sz == 1) return a % 4;
    if (sz == 2) return ((a % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic bit [31:0] exp_load(input bit [31:0] w, input bit [2:0] dw, input bit [31:0] a);
    int unsigned sz = acc_size(dw);
    int unsigned st = acc_start(dw, a);
    bit [31:0] mask, val;
    if (sz == 4) return w;
    mask = (32'h1 << (8 * sz)) - 1;
    val  = (w >> (8 * st)) & mask;
    if ((dw == 3'b001 || dw == 3'b010) && val >= (32'h1 << (8 * sz - 1))) val = val | ~mask;
    return val;
  endfunction

  function automatic void model_load(input bit [31:0] a, input bit [2:0] dw,
                                     output bit hit, output bit [31:0] exp_r);
    int unsigned idx = (a / 4) % SETS;
    int unsigned tg  = a / (4 * SETS);
    hit = mv[idx] && mt[idx] == tg;
    if (hit) m_hits++;
    else begin
      m_miss++;
      mv[idx] = 1; mt[idx] = tg; md[idx] = getmem(a / 4);
    end
    exp_r = exp_load(md[idx], dw, a);
  endfunction

  function automatic void model_store(input bit [31:0] a, input bit [2:0] dw, input bit [31:0] wd,
                                      output bit hit, output bit [3:0] strb, output bit [31:0] lanes);
    int unsigned idx = (a / 4) % SETS;
    int unsigned tg  = a / (4 * SETS);
    int unsigned sz  = acc_size(dw);
    int unsigned st  = acc_start(dw, a);
    bit [31:0] w = getmem(a / 4);
    hit = mv[idx] && mt[idx] == tg;
    if (hit) m_hits++; else m_miss++;
    strb = '0; lanes = '0;
    for (int unsigned j = st; j < st + sz; j++) begin
      strb[j] = 1'b1;
      lanes[8*j +: 8] = wd[8*(j-st) +: 8];
      w[8*j +: 8] = wd[8*(j-st) +: 8];
      if (hit) md[idx][8*j +: 8] = wd[8*(j-st) +: 8];
    end
    mem[a / 4] = w;
  endfunction

  function automatic bit [31:0] lane_mask(input bit [3:0] s);
    bit [31:0] m = '0;
    for (int unsigned j = 0; j < 4; j++) if (s[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  // Drives one access, plays the memory with an ack on the ack_delay-th request cycle,
  // and reports what was observed. Returns one cycle after Stall falls.
  task automatic access(input bit we, input bit [2:0] dw, input bit [31:0] a, input bit [31:0] wd,
                        input bit [31:0] rd_word, input int ack_delay,
                        output bit [31:0] g_rdata, output int stalls, output bit saw_req,
                        output bit g_we, output bit [31:0] g_addr, output bit [31:0] g_wdata,
                        output bit [3:0] g_strb, output bit changed, output bit timeout);
    int reqs = 0;
    CacheEn = 1'b1; MemWrite = we; DataWidth = dw; addr = a; wdata = wd;
    stalls = 0; saw_req = 0; changed = 0; timeout = 1; g_rdata = '0;
    g_we = 0; g_addr = '0; g_wdata = '0; g_strb = '0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!Stall) begin
        g_rdata = rdata; timeout = 0;
        break;
      end
      stalls++;
      if (mem_req) begin
        if (!saw_req) begin
          g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata; g_strb = mem_wstrb;
        end else if (g_we !== mem_we || g_addr !== mem_addr || g_wdata !== mem_wdata || g_strb !== mem_wstrb)
          changed = 1;
        saw_req = 1; reqs++;
        if (reqs >= ack_delay) begin mem_ack = 1'b1; mem_rdata = rd_word; end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    @(posedge clk); #1;
    CacheEn = 1'b0;
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({Stall, mem_req, mem_we, mem_wstrb, rdata, hit_count, miss_count} !== '0)
      $display("FAIL reset_state: got stall=%b req=%b we=%b strb=%b rdata=%h hit=%0d miss=%0d, want all zero",
               Stall, mem_req, mem_we, mem_wstrb, rdata, hit_count, miss_count);
    else pass_cnt++;
  endtask

  task automatic test_cold_load;
    bit h; bit [31:0] er, gr, ga, gw; int st; bit sr, gwe, ch, to; bit [3:0] gs;
    mem[32'h100 / 4] = 32'hDEADBEEF;
    model_load(32'h100, 3'b000, h, er);
    access(0, 3'b000, 32'h100, '0, 32'hDEADBEEF, 2, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (to || st != 3 || gr !== 32'hDEADBEEF || miss_count !== 16'd1)
      $display("FAIL cold_load: got stall_cycles=%0d rdata=%h miss=%0d timeout=%b, want 3 DEADBEEF 1 0",
               st, gr, miss_count, to);
    else pass_cnt++;
    total_cnt++;
    if (ga !== 32'h100 || gwe !== 1'b0 || gs !== 4'b0000)
      $display("FAIL refill_req: got addr=%h we=%b strb=%b, want 00000100 0 0000", ga, gwe, gs);
    else pass_cnt++;
    model_load(32'h100, 3'b000, h, er);
    access(0, 3'b000, 32'h100, '0, '0, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (to || st != 0 || gr !== 32'hDEADBEEF || hit_count !== 16'd1)
      $display("FAIL repeat_hit: got stall_cycles=%0d rdata=%h hit=%0d, want 0 DEADBEEF 1", st, gr, hit_count);
    else pass_cnt++;
  endtask

  task automatic test_extract;
    bit [31:0] exp_s [4] = '{32'hFFFFFF81, 32'h0000007F, 32'hFFFFFFF0, 32'hFFFFFF80};
    bit [31:0] exp_u [4] = '{32'h81, 32'h7F, 32'hF0, 32'h80};
    bit h; bit [31:0] er, gr, ga, gw; int st; bit sr, gwe, ch, to; bit [3:0] gs;
    mem[32'h300 / 4] = 32'h80F07F81;
    model_load(32'h300, 3'b000, h, er);
    access(0, 3'b000, 32'h300, '0, 32'h80F07F81, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    for (int unsigned o = 0; o < 4; o++) begin
      model_load(32'h300 + o, 3'b010, h, er);
      access(0, 3'b010, 32'h300 + o, '0, '0, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
      total_cnt++;
      if (to || st != 0 || gr !== exp_s[o])
        $display("FAIL byte_signed_off%0d: got %h stall=%0d, want %h stall=0", o, gr, st, exp_s[o]);
      else pass_cnt++;
      model_load(32'h300 + o, 3'b110, h, er);
      access(0, 3'b110, 32'h300 + o, '0, '0, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
      total_cnt++;
      if (to || st != 0 || gr !== exp_u[o])
        $display("FAIL byte_unsigned_off%0d: got %h stall=%0d, want %h stall=0", o, gr, st, exp_u[o]);
      else pass_cnt++;
    end
  endtask

  task automatic test_store_byte;
    bit h; bit [31:0] er, gr, ga, gw, ln; int st; bit sr, gwe, ch, to; bit [3:0] gs, es;
    model_load(32'h100, 3'b000, h, er);
    access(0, 3'b000, 32'h100, '0, getmem(32'h100 / 4), 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    model_store(32'h101, 3'b010, 32'h000000AB, h, es, ln);
    access(1, 3'b010, 32'h101, 32'h000000AB, '0, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (to || st != 2 || gs !== 4'b0010 || gw[15:8] !== 8'hAB || gwe !== 1'b1 || ga !== 32'h100)
      $display("FAIL store_byte: got stall=%0d strb=%b lane1=%h we=%b addr=%h, want 2 0010 AB 1 00000100",
               st, gs, gw[15:8], gwe, ga);
    else pass_cnt++;
    model_load(32'h100, 3'b000, h, er);
    access(0, 3'b000, 32'h100, '0, '0, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (to || st != 0 || gr !== 32'hDEADABEF)
      $display("FAIL store_byte_readback: got %h stall=%0d, want DEADABEF stall=0", gr, st);
    else pass_cnt++;
  endtask

  task automatic test_store_uncached;
    bit h; bit [31:0] er, gr, ga, gw, ln; int st; bit sr, gwe, ch, to; bit [3:0] gs, es;
    bit [15:0] m0;
    model_store(32'h202, 3'b001, 32'h5A5A1234, h, es, ln);
    access(1, 3'b001, 32'h202, 32'h5A5A1234, '0, 2, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (to || st != 3 || gs !== 4'b1100 || gw[31:16] !== 16'h1234 || ch)
      $display("FAIL store_half_miss: got stall=%0d strb=%b hi=%h changed=%b, want 3 1100 1234 0",
               st, gs, gw[31:16], ch);
    else pass_cnt++;
    m0 = miss_count;
    model_load(32'h200, 3'b000, h, er);
    access(0, 3'b000, 32'h200, '0, getmem(32'h200 / 4), 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (to || st != 2 || miss_count !== m0 + 16'd1 || gr !== er)
      $display("FAIL load_after_nwa: got stall=%0d miss=%0d rdata=%h, want 2 %0d %h", st, miss_count, gr, m0 + 1, er);
    else pass_cnt++;
  endtask

  task automatic test_conflict;
    bit h; bit [31:0] er, gr, ga, gw, a; int st; bit sr, gwe, ch, to; bit [3:0] gs;
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? 32'h000 : 32'h040;
      model_load(a, 3'b000, h, er);
      access(0, 3'b000, a, '0, getmem(a / 4), 1 + (i % 3), gr, st, sr, gwe, ga, gw, gs, ch, to);
      total_cnt++;
      if (to || st != 2 + (i % 3) || miss_count !== m_miss || gr !== er)
        $display("FAIL conflict_%0d: got stall=%0d miss=%0d rdata=%h, want %0d %0d %h",
                 i, st, miss_count, gr, 2 + (i % 3), m_miss, er);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_refill;
    bit h; bit [31:0] er, gr, ga, gw; int st; bit sr, gwe, ch, to; bit [3:0] gs;
    int waited = 0;
    CacheEn = 1'b1; MemWrite = 1'b0; DataWidth = 3'b000; addr = 32'h500;
    while (!mem_req && waited < 10) begin @(posedge clk); #1; waited++; end
    total_cnt++;
    if (!mem_req) $display("FAIL mid_refill_req: got mem_req=%b, want 1", mem_req);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0; CacheEn = 1'b0;
    #1;
    total_cnt++;
    if (mem_req !== 1'b0 || Stall !== 1'b0 || hit_count !== '0 || miss_count !== '0)
      $display("FAIL async_reset: got req=%b stall=%b hit=%0d miss=%0d, want 0 0 0 0",
               mem_req, Stall, hit_count, miss_count);
    else pass_cnt++;
    @(posedge clk); #1; rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1; mem_ack = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (mem_req !== 1'b0 || hit_count !== '0 || miss_count !== '0)
      $display("FAIL stray_ack: got req=%b hit=%0d miss=%0d, want 0 0 0", mem_req, hit_count, miss_count);
    else pass_cnt++;
    for (int unsigned i = 0; i < SETS; i++) mv[i] = 0;
    m_hits = 0; m_miss = 0;
    model_load(32'h500, 3'b000, h, er);
    access(0, 3'b000, 32'h500, '0, getmem(32'h500 / 4), 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (to || st != 2 || miss_count !== 16'd1 || gr !== er)
      $display("FAIL post_reset_miss: got stall=%0d miss=%0d rdata=%h, want 2 1 %h", st, miss_count, gr, er);
    else pass_cnt++;
  endtask

  task automatic test_random;
    bit [2:0] dws [8] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b011, 3'b100, 3'b111};
    bit h; bit [31:0] er, gr, ga, gw, a, wd, ln; int st, dly, est; bit sr, gwe, ch, to, we;
    bit [3:0] gs, es; bit [2:0] dw;
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3)
         | ($urandom_range(0, 1) << 31);
      dw = dws[$urandom_range(0, 7)];
      we = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      dly = $urandom_range(1, 4);
      if (we) begin
        model_store(a, dw, wd, h, es, ln);
        access(1, dw, a, wd, $urandom, dly, gr, st, sr, gwe, ga, gw, gs, ch, to);
        total_cnt++;
        if (to || st != 1 + dly || gs !== es || (gw & lane_mask(es)) !== ln || gwe !== 1'b1
            || ga !== {a[31:2], 2'b00} || ch)
          $display("FAIL rand_store_%0d: addr=%h dw=%b got stall=%0d strb=%b wdata=%h we=%b maddr=%h chg=%b, want %0d %b %h(lanes) 1 %h 0",
                   n, a, dw, st, gs, gw, gwe, ga, ch, 1 + dly, es, ln, {a[31:2], 2'b00});
        else pass_cnt++;
      end else begin
        model_load(a, dw, h, er);
        access(0, dw, a, '0, md[(a / 4) % SETS], dly, gr, st, sr, gwe, ga, gw, gs, ch, to);
        est = h ? 0 : 1 + dly;
        total_cnt++;
        if (to || st != est || gr !== er || (!h && (gwe !== 1'b0 || gs !== 4'b0000 || ga !== {a[31:2], 2'b00})))
          $display("FAIL rand_load_%0d: addr=%h dw=%b got stall=%0d rdata=%h we=%b strb=%b maddr=%h, want %0d %h",
                   n, a, dw, st, gr, gwe, gs, ga, est, er);
        else pass_cnt++;
      end
      total_cnt++;
      if (hit_count !== m_hits || miss_count !== m_miss)
        $display("FAIL rand_counters_%0d: got hit=%0d miss=%0d, want %0d %0d", n, hit_count, miss_count, m_hits, m_miss);
      else pass_cnt++;
    end
  endtask

  task automatic test_counter_wrap;
    bit h; bit [31:0] er, gr, ga, gw; int st, n; bit sr, gwe, ch, to; bit [3:0] gs;
    model_load(32'h700, 3'b000, h, er);
    access(0, 3'b000, 32'h700, '0, getmem(32'h700 / 4), 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    n = 65535 - int'(m_hits);
    for (int i = 0; i < n; i++) begin
      model_load(32'h700, 3'b000, h, er);
      access(0, 3'b000, 32'h700, '0, '0, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    end
    total_cnt++;
    if (hit_count !== 16'hFFFF || m_hits !== 16'hFFFF)
      $display("FAIL hit_count_max: got %h, want FFFF", hit_count);
    else pass_cnt++;
    model_load(32'h700, 3'b000, h, er);
    access(0, 3'b000, 32'h700, '0, '0, 1, gr, st, sr, gwe, ga, gw, gs, ch, to);
    total_cnt++;
    if (hit_count !== m_hits || hit_count !== 16'h0000)
      $display("FAIL hit_count_wrap: got %h, want 0000", hit_count);
    else pass_cnt++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_cold_load;
    test_extract;
    test_store_byte;
    test_store_uncached;
    test_conflict;
    test_reset_mid_refill;
    test_random;
    test_counter_wrap;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
